lcd_char_feeder: RTL and testbench

Character feeder that sits directly upstream of the team's 4-bit HD44780-style LCD write controller. It accepts ASCII bytes from a producer over a valid/ready handshake and buffers them in a small FIFO. It then issues them to the LCD controller as single-cycle write strobes, paced to that controller's fixed per-character cost. The LCD controller has no busy/done output, so this block owns power-on-init hold-off and inter-character pacing purely by cycle counting.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_char_fifo.sv | 92 +++++++++
 rtl/lcd_char_feeder.sv | 123 ++++++++++++
 tb/tb_lcd_char_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the character-LCD path: the feeder's pacing
// state encoding and the default timing constants that both the feeder
// and the 4-bit LCD write controller are sized against.
// No ports (package only).

package lcd_pkg;

  // Pacing FSM states of the character feeder.
  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } feederState_e;

  // Power-on hold-off; must exceed the LCD controller's complete init sequence.
  localparam int unsigned LCD_INIT_CYCLES = 32'd1100000;

  // Hold after each strobe; must exceed MSN + delay + LSN + wait (~2090 cycles).
  localparam int unsigned LCD_CHAR_CYCLES = 32'd2200;

endpackage

// File: rtl/lcd_char_fifo.sv
// lcd_char_fifo
// Small circular byte FIFO with wrapping read/write pointers and an
// occupancy counter. No bypass paths in either direction: a full FIFO
// refuses a push even when a pop happens in the same cycle, and a byte
// pushed this cycle can be popped no earlier than the next cycle.
// Ports:
//   Clock       rising-edge system clock
//   Reset       synchronous, active-high
//   push_i      write request (ignored while full)
//   pushData_i  byte to write
//   pop_i       read request (ignored while empty)
//   popData_o   head byte, valid while not empty
//   count_o     occupancy, 0..DEPTH
//   full_o      occupancy == DEPTH
//   empty_o     occupancy == 0

module lcd_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic [7:0]               pushData_i,
  input  logic                     pop_i,
  output logic [7:0]               popData_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush;
  logic          doPop;

  // Full/empty come only from the registered occupancy, which is what
  // rules out both bypass paths.
  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i  && !empty_o;

  // Next-state for pointers and occupancy. DEPTH is a power of two, so
  // the pointers wrap on their own when they overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; a reset flushes the FIFO.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array. Contents need no reset because the occupancy counter
  // decides what is valid.
  always_ff @(posedge Clock) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/lcd_char_feeder.sv
// lcd_char_feeder
// Buffers ASCII bytes from a producer and feeds them to the 4-bit LCD
// write controller as one-cycle write strobes. The controller reports no
// busy/done, so this block times the power-on hold-off and the
// per-character spacing purely by counting cycles.
// Ports:
//   Clock           rising-edge system clock
//   Reset           synchronous, active-high (shared with the LCD controller)
//   iValid, iChar   producer handshake and character code
//   oReady          FIFO has room; transfer on iValid && oReady
//   oWrite_Enabled  one-cycle write strobe to the LCD controller
//   oData           character for the controller, held through the character
//   oInitDone       init hold-off complete, sticky until Reset
//   oBusy           a character is being strobed or held
//   oCount          FIFO occupancy, 0..DEPTH

module lcd_char_feeder
  import lcd_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int unsigned INIT_CYCLES = LCD_INIT_CYCLES,
  parameter int unsigned CHAR_CYCLES = LCD_CHAR_CYCLES
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iValid,
  input  logic [7:0]               iChar,
  output logic                     oReady,
  output logic                     oWrite_Enabled,
  output logic [7:0]               oData,
  output logic                     oInitDone,
  output logic                     oBusy,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
  localparam logic [31:0] CHAR_LAST = 32'(CHAR_CYCLES - 1);

  feederState_e state_q;
  logic [31:0]  timer_q;
  logic [7:0]   data_q;
  logic         writeEn_q;
  logic         initDone_q;

  logic         fifoFull;
  logic         fifoEmpty;
  logic [7:0]   fifoHead;
  logic         popReq;

  // A pop happens only on an IDLE cycle with something queued; the same
  // condition moves the FSM to STROBE and loads oData.
  assign popReq = (state_q == S_IDLE) && !fifoEmpty;

  lcd_char_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push_i     (iValid),
    .pushData_i (iChar),
    .pop_i      (popReq),
    .popData_o  (fifoHead),
    .count_o    (oCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign oReady         = !fifoFull;
  assign oWrite_Enabled = writeEn_q;
  assign oData          = data_q;
  assign oInitDone      = initDone_q;
  assign oBusy          = (state_q == S_STROBE) || (state_q == S_HOLD);

  // Pacing FSM. The strobe is a registered decode of the STROBE state, so
  // it rises one cycle after the pop, when oData has already settled for a
  // full cycle. oData only changes on a pop because the LCD controller
  // samples iData combinationally while it works through a character.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_INIT;
      timer_q    <= '0;
      data_q     <= 8'h00;
      writeEn_q  <= 1'b0;
      initDone_q <= 1'b0;
    end else begin
      writeEn_q <= (state_q == S_STROBE);
      case (state_q)
        S_INIT: begin
          if (timer_q == INIT_LAST) begin
            initDone_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= S_IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_IDLE: begin
          if (popReq) begin
            data_q  <= fifoHead;
            state_q <= S_STROBE;
          end
        end
        S_STROBE: begin
          timer_q <= '0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (timer_q == CHAR_LAST) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: begin
          timer_q <= '0;
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb_lcd_char_feeder
// Directed bench for lcd_char_feeder with DEPTH=4, INIT_CYCLES=20,
// CHAR_CYCLES=10. Accepted bytes go into a scoreboard queue; every
// observed write strobe pops the queue and checks the character.

module tb_lcd_char_feeder;

  localparam int DEPTH = 4;
  localparam int INIT  = 20;
  localparam int CHAR  = 10;

  logic                     Clock;
  logic                     Reset;
  logic                     iValid;
  logic [7:0]               iChar;
  logic                     oReady;
  logic                     oWrite_Enabled;
  logic [7:0]               oData;
  logic                     oInitDone;
  logic                     oBusy;
  logic [$clog2(DEPTH):0]   oCount;

  int          testCount      = 0;
  int          failCount      = 0;
  int          edgeCount      = 0;
  int          lastStrobeEdge = -1;
  logic [7:0]  expQ[$];
  int          strobeEdges[$];

  lcd_char_feeder #(
    .DEPTH       (DEPTH),
    .INIT_CYCLES (INIT),
    .CHAR_CYCLES (CHAR)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iValid         (iValid),
    .iChar          (iChar),
    .oReady         (oReady),
    .oWrite_Enabled (oWrite_Enabled),
    .oData          (oData),
    .oInitDone      (oInitDone),
    .oBusy          (oBusy),
    .oCount         (oCount)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and counts and reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock, sample #1 after the edge, and act as the strobe
  // monitor: each strobe is scored against the queue, must be one cycle
  // wide, must see the same oData in the preceding cycle, and oData must
  // not change sooner than CHAR+1 cycles after a strobe.
  task automatic step();
    logic       rstAtEdge;
    logic [7:0] dataBefore;
    logic       weBefore;
    logic [7:0] expChar;
    rstAtEdge  = Reset;
    dataBefore = oData;
    weBefore   = oWrite_Enabled;
    @(posedge Clock);
    #1;
    edgeCount++;
    if (!rstAtEdge) begin
      if (oData !== dataBefore && lastStrobeEdge >= 0) begin
        checkOutput("dataHoldAfterStrobe", 32'((edgeCount - lastStrobeEdge) >= CHAR + 1), 32'd1);
      end
      if (oWrite_Enabled) begin
        if (weBefore) begin
          checkOutput("strobeWidth", weBefore, 1'b0);
        end
        if (expQ.size() == 0) begin
          checkOutput("strobeWithEmptyQueue", oWrite_Enabled, 1'b0);
        end else begin
          expChar = expQ.pop_front();
          checkOutput("strobeData", oData, expChar);
          checkOutput("dataBeforeStrobe", dataBefore, expChar);
        end
        strobeEdges.push_back(edgeCount);
        lastStrobeEdge = edgeCount;
      end
    end
  endtask

  task automatic runUntil(input int target);
    while (edgeCount < target) step();
  endtask

  // Offer one byte until accepted or the budget runs out; returns the edge
  // index of acceptance (-1 if never accepted).
  task automatic applyStimulus(input logic [7:0] ch, input int budget, output int acceptEdge);
    logic readyBefore;
    iValid     = 1'b1;
    iChar      = ch;
    acceptEdge = -1;
    for (int i = 0; i < budget; i++) begin
      readyBefore = oReady;
      step();
      if (readyBefore) begin
        expQ.push_back(ch);
        acceptEdge = edgeCount;
        break;
      end
    end
    iValid = 1'b0;
  endtask

  // Reset for two edges; edge 0 is the last edge that samples Reset high.
  task automatic doReset();
    Reset  = 1'b1;
    iValid = 1'b0;
    step();
    step();
    Reset          = 1'b0;
    edgeCount      = 0;
    lastStrobeEdge = -1;
    expQ.delete();
    strobeEdges.delete();
  endtask

  initial begin
    int          a;
    logic [7:0]  hola [4];
    hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41;
    Reset  = 1'b1;
    iValid = 1'b0;
    iChar  = 8'h00;

    // Reset values, then init hold-off with an empty FIFO.
    step(); step(); step();
    checkOutput("rstWrite",    oWrite_Enabled, 1'b0);
    checkOutput("rstData",     oData,          8'h00);
    checkOutput("rstInitDone", oInitDone,      1'b0);
    checkOutput("rstBusy",     oBusy,          1'b0);
    checkOutput("rstCount",    oCount,         3'd0);
    checkOutput("rstReady",    oReady,         1'b1);
    Reset          = 1'b0;
    edgeCount      = 0;
    lastStrobeEdge = -1;
    for (int k = 1; k <= INIT + 5; k++) begin
      step();
      checkOutput("initDoneTiming", oInitDone, 32'(k >= INIT));
      checkOutput("idleNotBusy",    oBusy,     1'b0);
    end
    checkOutput("idleNoStrobes", strobeEdges.size(), 0);

    // A byte pushed during init strobes two edges after oInitDone.
    doReset();
    applyStimulus(8'h48, 5, a);
    checkOutput("t2AcceptEdge", a, 1);
    runUntil(30);
    checkOutput("t2StrobeCount", strobeEdges.size(), 1);
    if (strobeEdges.size() >= 1) checkOutput("t2StrobeEdge", strobeEdges[0], INIT + 2);

    // "HOLA" back to back after init: strobes exactly CHAR+2 apart.
    doReset();
    runUntil(INIT);
    checkOutput("t3InitDone", oInitDone, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(hola[i], 5, a);
      checkOutput("t3AcceptEdge", a, INIT + 1 + i);
    end
    runUntil(65);
    checkOutput("t3StrobeCount", strobeEdges.size(), 4);
    if (strobeEdges.size() == 4) begin
      checkOutput("t3FirstStrobe", strobeEdges[0], INIT + 3);
      for (int i = 1; i < 4; i++) begin
        checkOutput("t3Spacing", strobeEdges[i] - strobeEdges[i-1], CHAR + 2);
      end
    end
    checkOutput("t3Drained", expQ.size(), 0);

    // Fill during init, 5th byte waits for the first pop.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 * (i + 1), 3, a);
    checkOutput("t4FullReady", oReady, 1'b0);
    checkOutput("t4FullCount", oCount, 3'd4);
    applyStimulus(8'h50, 40, a);
    checkOutput("t4FifthAccept", a, INIT + 2);
    runUntil(75);
    checkOutput("t4StrobeCount", strobeEdges.size(), 5);
    checkOutput("t4Drained", expQ.size(), 0);

    // Push during a pop at occupancy 2, then wrap the pointers.
    doReset();
    applyStimulus(8'h61, 3, a);
    applyStimulus(8'h62, 3, a);
    runUntil(INIT);
    checkOutput("t5CountBefore", oCount, 3'd2);
    applyStimulus(8'h63, 3, a);
    checkOutput("t5PushPopEdge", a, INIT + 1);
    checkOutput("t5PushPopCount", oCount, 3'd2);
    for (int i = 0; i < 4; i++) applyStimulus(8'h64 + 8'(i), 40, a);
    for (int i = 0; i < 300 && (expQ.size() != 0 || oBusy); i++) step();
    checkOutput("t5Drained", expQ.size(), 0);
    checkOutput("t5CountEnd", oCount, 3'd0);
    checkOutput("t5StrobeCount", strobeEdges.size(), 7);

    // Reset while holding a character with three bytes still queued.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h31 + 8'(i), 3, a);
    runUntil(25);
    checkOutput("t6CountHold", oCount, 3'd3);
    checkOutput("t6BusyHold",  oBusy,  1'b1);
    Reset = 1'b1;
    step();
    checkOutput("t6RstCount",    oCount,         3'd0);
    checkOutput("t6RstWrite",    oWrite_Enabled, 1'b0);
    checkOutput("t6RstInitDone", oInitDone,      1'b0);
    checkOutput("t6RstReady",    oReady,         1'b1);
    Reset          = 1'b0;
    edgeCount      = 0;
    lastStrobeEdge = -1;
    expQ.delete();
    strobeEdges.delete();
    for (int k = 1; k <= INIT + 5; k++) begin
      step();
      checkOutput("t6InitDoneTiming", oInitDone, 32'(k >= INIT));
    end
    checkOutput("t6NoStrobes", strobeEdges.size(), 0);
    checkOutput("t6CountEnd",  oCount, 3'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
